// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the cordic_core sharing controller: register map,
// controller states and the timeout counter sizing helper.
package cordic_ctrl_pkg;

  localparam logic [5:0] ADDR_ANGLE = 6'h04;
  localparam logic [5:0] ADDR_COS   = 6'h08;
  localparam logic [5:0] ADDR_SIN   = 6'h0C;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    SETTLE,
    WAIT,
    RD_COS,
    RD_SIN,
    RD_END,
    RESP
  } state_t;

  // The wait counter only has to reach timeout-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant,
// wrapping around. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Offset NUM_REQ lands back on last_grant, so it is considered last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic_core between NUM_REQ requesters: round-robin grant,
// core register-bus sequencing and a per-requester valid/ready response.
module cordic_arbiter
  import cordic_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_angle,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_cos,
  output logic [31:0]           rsp_sin,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  core_bus_write,
  output logic                  core_bus_read,
  output logic [5:0]            core_addr,
  output logic [31:0]           core_wdata,
  input  logic [31:0]           core_rdata,
  input  logic                  core_done
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     angle_q, angle_d;
  logic [31:0]     cos_q, cos_d;
  logic [31:0]     sin_q, sin_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic [31:0]        grant_angle;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    grant_angle = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_angle = req_angle[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= '0;
      id_q         <= '0;
      angle_q      <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      angle_q      <= angle_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    id_d           = id_q;
    angle_d        = angle_q;
    cos_d          = cos_q;
    sin_d          = sin_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    req_ready      = '0;
    rsp_valid      = '0;
    core_bus_write = 1'b0;
    core_bus_read  = 1'b0;
    core_addr      = '0;
    core_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        // grant is only ever set for a valid requester, so ready implies transfer
        req_ready = grant;
        if (|grant) begin
          angle_d      = grant_angle;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = WR;
        end
      end
      WR: begin
        core_bus_write = 1'b1;
        core_addr      = ADDR_ANGLE;
        core_wdata     = angle_q;
        state_d        = SETTLE;
      end
      SETTLE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_d = RD_COS;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cos_d   = '0;
          sin_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_COS: begin
        core_bus_read = 1'b1;
        core_addr     = ADDR_COS;
        state_d       = RD_SIN;
      end
      RD_SIN: begin
        core_bus_read = 1'b1;
        core_addr     = ADDR_SIN;
        cos_d         = core_rdata;
        state_d       = RD_END;
      end
      RD_END: begin
        sin_d   = core_rdata;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_cos = cos_q;
  assign rsp_sin = sin_q;
  assign rsp_err = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural cordic_core stub:
// done D cycles after the angle write, cos = angle+1, sin = ~angle.
module tb_cordic_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 256;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_angle = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready = '1;
  logic [31:0]           rsp_cos, rsp_sin;
  logic                  rsp_err, busy;
  logic                  core_bus_write, core_bus_read;
  logic [5:0]            core_addr;
  logic [31:0]           core_wdata, core_rdata;
  logic                  core_done;

  int checks = 0;
  int errors = 0;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_angle      (req_angle),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_cos        (rsp_cos),
    .rsp_sin        (rsp_sin),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .core_bus_write (core_bus_write),
    .core_bus_read  (core_bus_read),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_rdata     (core_rdata),
    .core_done      (core_done)
  );

  always #5 clk = ~clk;

  // cordic_core stub, sharing rst with the DUT
  int          stub_d     = 0;
  logic        stub_never = 1'b0;
  logic        stale_arm  = 1'b0;
  int          arm_at     = 0;
  int          wr_count;
  int          stub_cnt;
  logic        stub_active, stub_done_q;
  logic [31:0] stub_angle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count    <= 0;
      stub_cnt    <= 0;
      stub_active <= 1'b0;
      stub_done_q <= 1'b0;
      stub_angle  <= '0;
      core_rdata  <= '0;
    end else begin
      core_rdata <= '0;
      if (core_bus_read && core_addr == 6'h08) core_rdata <= stub_angle + 32'd1;
      if (core_bus_read && core_addr == 6'h0C) core_rdata <= ~stub_angle;
      if (core_bus_write && core_addr == 6'h04) begin
        stub_angle  <= core_wdata;
        stub_active <= 1'b1;
        stub_cnt    <= 0;
        stub_done_q <= 1'b0;
        wr_count    <= wr_count + 1;
      end else if (stub_active) begin
        if (!stub_never && stub_cnt == stub_d) begin
          stub_done_q <= 1'b1;
          stub_active <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  // stale_arm models a done left high from a previous operation until the next write
  assign core_done = stub_done_q | (stale_arm && (wr_count == arm_at));

  // bus monitor: cyc is the index of the cycle ending at each rising edge
  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } bus_ev_t;

  bus_ev_t bus_log[$];
  int      cyc      = 0;
  int      both_err = 0;

  always @(posedge clk) begin
    if (core_bus_write || core_bus_read)
      bus_log.push_back('{core_bus_write, core_addr, core_wdata, cyc});
    if (core_bus_write && core_bus_read) both_err++;
    cyc <= cyc + 1;
  end

  typedef struct {
    int          id;
    logic [31:0] angle;
    int          d;
    logic [31:0] exp_cos;
    logic [31:0] exp_sin;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic waitRsp(input int id, input int budget, output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (rsp_valid[id]) begin
        found = 1'b1;
        t = cyc;
      end
    end
  endtask

  // Single request from one requester; returns transfer and response cycles.
  task automatic applyStimulus(input int id, input logic [31:0] angle, input int d,
                               output int t_x, output int t_r);
    @(negedge clk);
    stub_d = d;
    req_angle[id*32 +: 32] = angle;
    req_valid[id] = 1'b1;
    #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'(1 << id));
    checkOutput("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    t_x = cyc;
    #1;
    req_valid[id] = 1'b0;
    waitRsp(id, 400, t_r);
  endtask

  initial begin
    int t_x, t_r, n0, g;
    logic [31:0] hold_cos, hold_sin;
    logic found;

    vecs[0] = '{0, 32'h1000_0000, 16, 32'h1000_0001, 32'hEFFF_FFFF, 23};
    vecs[1] = '{2, 32'h7FFF_FFFF, 5,  32'h8000_0000, 32'h8000_0000, 12};
    vecs[2] = '{1, 32'hFFFF_FFFF, 0,  32'h0000_0000, 32'h0000_0000, 7};
    vecs[3] = '{3, 32'h8000_0000, 2,  32'h8000_0001, 32'h7FFF_FFFF, 9};

    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_bus", {core_bus_write, core_bus_read, core_addr, 24'd0}, 32'd0);
    checkOutput("rst_cos", rsp_cos, 32'd0);
    checkOutput("rst_sin", rsp_sin, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // table: single requests; the last one leaves the pointer at 3
    for (int v = 0; v < 4; v++) begin
      n0 = bus_log.size();
      applyStimulus(vecs[v].id, vecs[v].angle, vecs[v].d, t_x, t_r);
      checkOutput("vec_latency", 32'(t_r - t_x), 32'(vecs[v].exp_lat));
      checkOutput("vec_rsp_valid", 32'(rsp_valid), 32'(1 << vecs[v].id));
      checkOutput("vec_cos", rsp_cos, vecs[v].exp_cos);
      checkOutput("vec_sin", rsp_sin, vecs[v].exp_sin);
      checkOutput("vec_err", 32'(rsp_err), 32'd0);
      checkOutput("vec_bus_count", 32'(bus_log.size() - n0), 32'd3);
      if (bus_log.size() >= n0 + 3) begin
        checkOutput("vec_wr", {31'd0, bus_log[n0].wr}, 32'd1);
        checkOutput("vec_wr_addr", 32'(bus_log[n0].addr), 32'h04);
        checkOutput("vec_wr_data", bus_log[n0].wdata, vecs[v].angle);
        checkOutput("vec_wr_cyc", 32'(bus_log[n0].cyc - t_x), 32'd1);
        checkOutput("vec_rd1_addr", 32'(bus_log[n0+1].addr), 32'h08);
        checkOutput("vec_rd1_cyc", 32'(bus_log[n0+1].cyc - t_x), 32'(4 + vecs[v].d));
        checkOutput("vec_rd2_addr", 32'(bus_log[n0+2].addr), 32'h0C);
      end
      @(negedge clk);
      checkOutput("vec_idle_after", 32'(busy), 32'd0);
    end

    // round-robin with all four requesters held valid
    @(negedge clk);
    stub_d = 2;
    for (int i = 0; i < NUM_REQ; i++) req_angle[i*32 +: 32] = 32'(i);
    req_valid = '1;
    for (int op = 0; op < 5; op++) begin
      g = op % NUM_REQ;
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
        #1;
        if (req_ready != '0) found = 1'b1;
        else @(negedge clk);
      end
      checkOutput("rr_grant", 32'(req_ready), 32'(1 << g));
      if (op == 4) begin
        @(posedge clk);
        #1;
        req_valid = '0;
      end
      waitRsp(g, 50, t_r);
      checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(1 << g));
      checkOutput("rr_cos", rsp_cos, 32'(g + 1));
    end

    // backpressure on requester 2 while requester 0 waits
    @(negedge clk);
    rsp_ready = 4'b1011;
    applyStimulus(2, 32'h1234_5678, 3, t_x, t_r);
    req_valid[0] = 1'b1;
    req_angle[31:0] = 32'hAAAA_0000;
    hold_cos = rsp_cos;
    hold_sin = rsp_sin;
    checkOutput("bp_cos", hold_cos, 32'h1234_5679);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_cos_hold", rsp_cos, hold_cos);
      checkOutput("bp_sin_hold", rsp_sin, hold_sin);
    end
    rsp_ready = '1;
    @(negedge clk);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkOutput("bp_release_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    waitRsp(0, 50, t_r);
    checkOutput("bp_next_cos", rsp_cos, 32'hAAAA_0001);

    // timeout: the core never finishes, so no reads may follow the write
    stub_never = 1'b1;
    n0 = bus_log.size();
    applyStimulus(1, 32'h0000_0055, 0, t_x, t_r);
    checkOutput("to_latency_window", 32'((t_r - t_x) >= 259 && (t_r - t_x) <= 260), 32'd1);
    checkOutput("to_err", 32'(rsp_err), 32'd1);
    checkOutput("to_cos", rsp_cos, 32'd0);
    checkOutput("to_sin", rsp_sin, 32'd0);
    checkOutput("to_bus_count", 32'(bus_log.size() - n0), 32'd1);
    @(negedge clk);
    stub_never = 1'b0;

    // stale done held high until the angle write lands
    arm_at = wr_count;
    stale_arm = 1'b1;
    n0 = bus_log.size();
    applyStimulus(0, 32'hF000_0000, 4, t_x, t_r);
    stale_arm = 1'b0;
    if (bus_log.size() >= n0 + 2)
      checkOutput("stale_first_read", 32'(bus_log[n0+1].cyc - t_x), 32'd8);
    else
      checkOutput("stale_bus_count", 32'(bus_log.size() - n0), 32'd3);
    checkOutput("stale_latency", 32'(t_r - t_x), 32'd11);
    checkOutput("stale_cos", rsp_cos, 32'hF000_0001);
    checkOutput("stale_err", 32'(rsp_err), 32'd0);

    // asynchronous reset in WAIT
    @(negedge clk);
    stub_d = 20;
    req_angle[3*32 +: 32] = 32'h0000_0011;
    req_valid[3] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("arst_bus", {core_bus_write, core_bus_read, core_addr, 24'd0}, 32'd0);
    checkOutput("arst_cos", rsp_cos, 32'd0);
    checkOutput("arst_sin", rsp_sin, 32'd0);
    checkOutput("arst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) found = 1'b1;
    end
    checkOutput("arst_no_rsp", 32'(found), 32'd0);
    // pointer back at 0: with 0 and 1 both pending, 1 wins
    req_angle[31:0]  = 32'h0000_0100;
    req_angle[63:32] = 32'h0000_0200;
    stub_d = 1;
    req_valid = 4'b0011;
    #1;
    checkOutput("arst_rr_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    waitRsp(1, 50, t_r);
    checkOutput("arst_next_valid", 32'(rsp_valid), 32'b0010);
    checkOutput("arst_next_cos", rsp_cos, 32'h0000_0201);

    checkOutput("bus_rw_exclusive", 32'(both_err), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
